// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param: parametrised fetch/decode/execute control FSM with ready-handshaked memory.
// Define CTRL_ILLEGAL_TRAP_EN to halt with a sticky illegal flag on bad register indices.
module ctrl_fsm_param #(
    parameter int OPW    = 6,
    parameter int NREG   = 3,
    parameter int ASEL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    ir,
    input  logic              mem_ready,
    output logic [ASEL_W-1:0] a_sel,
    output logic [2:0]        alu_op,
    output logic [NREG+3:0]   c_en,
    output logic              ld_ir,
    output logic              pc_inc,
    output logic              ac_inc,
    output logic [NREG-1:0]   r_inc,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              halted,
    output logic              illegal
);
    localparam int IW = OPW - 3;
    localparam int CW = NREG + 4;
    localparam logic [IW-1:0] NR = IW'(NREG);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST, S_F1, S_F2, S_DEC, S_MR1, S_MR2, S_LD3, S_ST3,
        S_ST4, S_ST5, S_MOV, S_ALU, S_INC, S_HALT
    } state_t;

    state_t            state_q, state_d, exec_st;
    logic [2:0]        op_q, op_d, ir_op;
    logic [IW-1:0]     idx_q, idx_d, ir_idx;
    logic              illegal_q, illegal_d, bad, halt_enc;
    logic [ASEL_W-1:0] a_sel_q, a_sel_d, reg_sel;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [CW-1:0]     c_en_q, c_en_d, reg_en;
    logic              ac_inc_q, ac_inc_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic              halted_q, halted_d, f2_q, f2_d, mr2_q, mr2_d;
    logic [NREG-1:0]   r_inc_q, r_inc_d;

    assign ir_op    = ir[OPW-1:OPW-3];
    assign ir_idx   = ir[IW-1:0];
    assign halt_enc = ir_op == 3'b111 && &ir_idx;
    assign bad      = (ir_op >= 3'b011 && ir_op <= 3'b110 && ir_idx >= NR) || (ir_op == 3'b111 && ir_idx > NR);
    assign exec_st  = ir_op == 3'b000 ? S_F1  :
                      ir_op <= 3'b010 ? S_MR1 :
                      ir_op <= 3'b100 ? S_MOV :
                      ir_op <= 3'b110 ? S_ALU : S_INC;
    assign reg_sel  = ASEL_W'(4) + ASEL_W'(idx_d);
    assign reg_en   = CW'(16) << idx_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RST:   state_d = S_F1;
            S_F1:    state_d = S_F2;
            S_F2:    state_d = mem_ready ? S_DEC : S_F2;
            S_DEC: begin
                op_d      = ir_op;
                idx_d     = ir_idx;
                state_d   = halt_enc ? S_HALT : bad ? (TRAP ? S_HALT : S_F1) : exec_st;
                illegal_d = illegal_q | (bad & ~halt_enc & TRAP);
            end
            S_MR1:   state_d = S_MR2;
            S_MR2:   state_d = !mem_ready ? S_MR2 : op_q == 3'b001 ? S_LD3 : S_ST3;
            S_ST3:   state_d = S_ST4;
            S_ST4:   state_d = S_ST5;
            S_ST5:   state_d = mem_ready ? S_F1 : S_ST5;
            S_LD3, S_MOV, S_ALU, S_INC: state_d = S_F1;
            default: state_d = state_q;
        endcase
    end

    // Moore outputs are decoded from the next state so the registered copy lines up with the state.
    always_comb begin
        a_sel_d  = '0;
        alu_op_d = '0;
        c_en_d   = '0;
        ac_inc_d = 1'b0;
        r_inc_d  = '0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        halted_d = 1'b0;
        f2_d     = 1'b0;
        mr2_d    = 1'b0;
        case (state_d)
            S_F1, S_MR1: begin
                a_sel_d = ASEL_W'(1);
                c_en_d  = CW'(2);
            end
            S_F2: begin
                mem_rd_d = 1'b1;
                f2_d     = 1'b1;
            end
            S_MR2: begin
                mem_rd_d = 1'b1;
                mr2_d    = 1'b1;
            end
            S_LD3: begin
                a_sel_d = ASEL_W'(3);
                c_en_d  = CW'(8);
            end
            S_ST3: begin
                a_sel_d = ASEL_W'(3);
                c_en_d  = CW'(2);
            end
            S_ST4: begin
                a_sel_d = ASEL_W'(2);
                c_en_d  = CW'(4);
            end
            S_ST5:   mem_wr_d = 1'b1;
            S_MOV: begin
                a_sel_d = op_d == 3'b011 ? ASEL_W'(2) : reg_sel;
                c_en_d  = op_d == 3'b011 ? reg_en : CW'(8);
            end
            S_ALU: begin
                a_sel_d  = reg_sel;
                alu_op_d = op_d == 3'b101 ? 3'd1 : 3'd2;
                c_en_d   = CW'(8);
            end
            S_INC: begin
                ac_inc_d = idx_d == NR;
                r_inc_d  = idx_d == NR ? '0 : NREG'(1) << idx_d;
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            op_q      <= '0;
            idx_q     <= '0;
            illegal_q <= 1'b0;
            a_sel_q   <= '0;
            alu_op_q  <= '0;
            c_en_q    <= '0;
            ac_inc_q  <= 1'b0;
            r_inc_q   <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            halted_q  <= 1'b0;
            f2_q      <= 1'b0;
            mr2_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            illegal_q <= illegal_d;
            a_sel_q   <= a_sel_d;
            alu_op_q  <= alu_op_d;
            c_en_q    <= c_en_d;
            ac_inc_q  <= ac_inc_d;
            r_inc_q   <= r_inc_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            halted_q  <= halted_d;
            f2_q      <= f2_d;
            mr2_q     <= mr2_d;
        end
    end

    // Ready-qualified strobes cannot be registered: they follow mem_ready in the same cycle.
    assign ld_ir   = f2_q & mem_ready;
    assign pc_inc  = (f2_q | mr2_q) & mem_ready;
    assign c_en    = c_en_q | (mr2_q && mem_ready ? CW'(4) : '0);
    assign a_sel   = a_sel_q;
    assign alu_op  = alu_op_q;
    assign ac_inc  = ac_inc_q;
    assign r_inc   = r_inc_q;
    assign mem_rd  = mem_rd_q;
    assign mem_wr  = mem_wr_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
endmodule
